// File: rtl/bcd_pkg.sv
// Shared types and sizing helpers for the binary-to-BCD conversion engine.
package bcd_pkg;

   localparam int unsigned MAX_WIDTH  = 32;
   localparam int unsigned MAX_DIGITS = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit counter must hold the value WIDTH itself.
   function automatic int unsigned cnt_width(input int unsigned width);
      int unsigned w;
      w = (width > MAX_WIDTH) ? MAX_WIDTH : width;
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/bcd_conv_ctrl_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more (mod 16).
module bcd_add3 (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit_c
);

   // Combinational correction of one BCD digit.
   always_comb begin
      o_digit_c = i_digit;
      if (i_digit >= 4'd5) begin
         o_digit_c = i_digit + 4'd3;
      end
   end

endmodule

// File: rtl/bcd_conv_ctrl.sv
// Time-shared iterative binary-to-BCD converter with a two-requester
// round-robin arbiter; one operand bit is consumed per clock.
module bcd_conv_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DIGITS = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req,
   input  logic [WIDTH-1:0]      bin0,
   input  logic [WIDTH-1:0]      bin1,
   output logic [1:0]            ack,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_id,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_ovf
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = cnt_width(WIDTH);
   localparam int unsigned N_ADJ = (DIGITS > MAX_DIGITS) ? MAX_DIGITS : DIGITS;

   state_t             r_state;
   state_t             w_next;
   logic               r_ptr;
   logic [WIDTH-1:0]   r_bin;
   logic [BCD_W-1:0]   r_bcd;
   logic [BCD_W-1:0]   w_adj;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_id;
   logic               r_ovf;
   logic [1:0]         w_ack;
   logic               w_gnt_id;
   logic               w_accept;
   logic               w_last;

   assign w_last   = (r_cnt == CNT_W'(1));
   assign w_accept = |w_ack;

   // Per-digit add-3 correction applied before every shift.
   for (genvar k = 0; k < N_ADJ; k++) begin : g_add3
      bcd_add3 u_add3 (
         .i_digit   (r_bcd[4*k +: 4]),
         .o_digit_c (w_adj[4*k +: 4])
      );
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and round-robin grant; grants only issue from IDLE.
   always_comb begin
      w_next   = r_state;
      w_ack    = 2'b00;
      w_gnt_id = 1'b0;
      case (r_state)
         IDLE: begin
            if (req != 2'b00) begin
               w_next = CONV;
               case (req)
                  2'b01:   w_gnt_id = 1'b0;
                  2'b10:   w_gnt_id = 1'b1;
                  default: w_gnt_id = r_ptr;
               endcase
               w_ack = w_gnt_id ? 2'b10 : 2'b01;
            end
         end
         CONV: begin
            if (w_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Pointer favours the requester that did not win the last grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= 1'b0;
      end else if (w_accept) begin
         r_ptr <= ~w_gnt_id;
      end
   end

   // Operand capture and shift-and-add-3 datapath; top-digit carry-out is sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin <= '0;
         r_bcd <= '0;
         r_cnt <= '0;
         r_id  <= 1'b0;
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_bin <= w_gnt_id ? bin1 : bin0;
         r_bcd <= '0;
         r_cnt <= CNT_W'(WIDTH);
         r_id  <= w_gnt_id;
         r_ovf <= 1'b0;
      end else if (r_state == CONV) begin
         r_bcd <= {w_adj[BCD_W-2:0], r_bin[WIDTH-1]};
         r_bin <= {r_bin[WIDTH-2:0], 1'b0};
         r_ovf <= r_ovf | w_adj[BCD_W-1];
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign ack       = w_ack;
   assign busy      = (r_state != IDLE);
   assign out_valid = (r_state == DONE);
   assign out_id    = r_id;
   assign out_bcd   = r_bcd;
   assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Directed self-checking bench for bcd_conv_ctrl in three configurations.
module tb_bcd_conv_ctrl;

   logic clk;
   logic rst;
   logic out_ready;
   int   cyc;
   int   n_checks;
   int   n_errors;
   int   sel;

   // Instance A: 32-bit / 10 digits
   logic [1:0]  req_a;
   logic [31:0] bin0_a, bin1_a;
   logic [1:0]  ack_a;
   logic        busy_a, valid_a, id_a, ovf_a;
   logic [39:0] bcd_a;
   // Instance B: 32-bit / 7 digits
   logic [1:0]  req_b;
   logic [31:0] bin0_b, bin1_b;
   logic [1:0]  ack_b;
   logic        busy_b, valid_b, id_b, ovf_b;
   logic [27:0] bcd_b;
   // Instance C: 4-bit / 2 digits
   logic [1:0]  req_c;
   logic [3:0]  bin0_c, bin1_c;
   logic [1:0]  ack_c;
   logic        busy_c, valid_c, id_c, ovf_c;
   logic [7:0]  bcd_c;

   // Selected-instance view
   logic [1:0]  m_ack;
   logic        m_busy, m_valid, m_id, m_ovf;
   logic [39:0] m_bcd;

   bcd_conv_ctrl #(.WIDTH(32), .DIGITS(10)) u_dut_a (
      .clk(clk), .rst(rst), .req(req_a), .bin0(bin0_a), .bin1(bin1_a),
      .ack(ack_a), .busy(busy_a), .out_valid(valid_a), .out_ready(out_ready),
      .out_id(id_a), .out_bcd(bcd_a), .out_ovf(ovf_a));

   bcd_conv_ctrl #(.WIDTH(32), .DIGITS(7)) u_dut_b (
      .clk(clk), .rst(rst), .req(req_b), .bin0(bin0_b), .bin1(bin1_b),
      .ack(ack_b), .busy(busy_b), .out_valid(valid_b), .out_ready(out_ready),
      .out_id(id_b), .out_bcd(bcd_b), .out_ovf(ovf_b));

   bcd_conv_ctrl #(.WIDTH(4), .DIGITS(2)) u_dut_c (
      .clk(clk), .rst(rst), .req(req_c), .bin0(bin0_c), .bin1(bin1_c),
      .ack(ack_c), .busy(busy_c), .out_valid(valid_c), .out_ready(out_ready),
      .out_id(id_c), .out_bcd(bcd_c), .out_ovf(ovf_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      m_ack = ack_a; m_busy = busy_a; m_valid = valid_a; m_id = id_a; m_ovf = ovf_a;
      m_bcd = bcd_a;
      if (sel == 1) begin
         m_ack = ack_b; m_busy = busy_b; m_valid = valid_b; m_id = id_b; m_ovf = ovf_b;
         m_bcd = {12'd0, bcd_b};
      end else if (sel == 2) begin
         m_ack = ack_c; m_busy = busy_c; m_valid = valid_c; m_id = id_c; m_ovf = ovf_c;
         m_bcd = {32'd0, bcd_c};
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int inst, input logic [1:0] rq, input logic [31:0] val);
      case (inst)
         0: begin
            req_a = rq;
            if (rq[0]) bin0_a = val; else if (rq[1]) bin1_a = val;
         end
         1: begin
            req_b = rq;
            if (rq[0]) bin0_b = val; else if (rq[1]) bin1_b = val;
         end
         default: begin
            req_c = rq;
            if (rq[0]) bin0_c = 4'(val); else if (rq[1]) bin1_c = 4'(val);
         end
      endcase
   endtask

   // Raise a single request, wait (bounded) for its grant, cross the accept edge, drop it.
   task automatic start_conv(input int inst, input logic [1:0] rq, input logic [31:0] val,
                             input string tag);
      int k;
      sel = inst;
      set_req(inst, rq, val);
      #1;
      k = 0;
      while (m_ack == 2'b00 && k < 60) begin
         next_cyc();
         k++;
      end
      check({tag, "_ack"}, 64'(m_ack), 64'(rq));
      next_cyc();
      set_req(inst, 2'b00, 32'd0);
      #1;
      check({tag, "_ack_off"}, 64'(m_ack), 64'd0);
      check({tag, "_busy"}, 64'(m_busy), 64'd1);
   endtask

   // Wait (bounded) for valid and check latency and result fields.
   task automatic wait_result(input int exp_lat, input logic [39:0] exp_bcd,
                              input logic exp_id, input logic exp_ovf, input string tag);
      int lat;
      lat = 0;
      while (!m_valid && lat < 100) begin
         next_cyc();
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_bcd"}, 64'(m_bcd), 64'(exp_bcd));
      check({tag, "_id"},  64'(m_id),  64'(exp_id));
      check({tag, "_ovf"}, 64'(m_ovf), 64'(exp_ovf));
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      next_cyc();
      out_ready = 1'b0;
      #1;
      check({tag, "_valid_off"}, 64'(m_valid), 64'd0);
   endtask

   initial begin
      logic [1:0] exp_g;
      int         t_prev;
      int         k;
      n_checks = 0; n_errors = 0; cyc = 0; sel = 0;
      rst = 1'b1; out_ready = 1'b0;
      req_a = 2'b00; bin0_a = '0; bin1_a = '0;
      req_b = 2'b00; bin0_b = '0; bin1_b = '0;
      req_c = 2'b00; bin0_c = '0; bin1_c = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", 64'(valid_a), 64'd0);
      check("rst_busy",  64'(busy_a),  64'd0);
      check("rst_ack",   64'(ack_a),   64'd0);
      check("rst_bcd",   64'(bcd_a),   64'd0);
      check("rst_id",    64'(id_a),    64'd0);
      check("rst_ovf",   64'(ovf_a),   64'd0);
      rst = 1'b0;
      next_cyc();

      // Full-scale 32-bit operand
      start_conv(0, 2'b01, 32'd4294967295, "max32");
      wait_result(32, 40'h4294967295, 1'b0, 1'b0, "max32");
      handshake("max32");

      // Output held while consumer stalls; new request blocked until handshake
      start_conv(0, 2'b01, 32'd9999, "hold");
      wait_result(32, 40'h0000009999, 1'b0, 1'b0, "hold");
      req_a = 2'b10; bin1_a = 32'd5;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("hold_valid", 64'(valid_a), 64'd1);
         check("hold_bcd",   64'(bcd_a),   64'h9999);
         check("hold_ack",   64'(ack_a),   64'd0);
         next_cyc();
      end
      handshake("hold");
      check("hold_ack_after", 64'(ack_a), 64'd2);
      start_conv(0, 2'b10, 32'd5, "hold_next");
      wait_result(32, 40'h5, 1'b1, 1'b0, "hold_next");
      handshake("hold_next");

      // Both requesters held: alternating grants, 34-cycle spacing
      sel = 0;
      bin0_a = 32'd111; bin1_a = 32'd222;
      req_a = 2'b11; out_ready = 1'b1;
      t_prev = 0;
      #1;
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         k = 0;
         while (ack_a == 2'b00 && k < 60) begin
            next_cyc();
            k++;
         end
         check("rr_grant", 64'(ack_a), 64'(exp_g));
         if (i > 0) check("rr_spacing", 64'(cyc - t_prev), 64'd34);
         t_prev = cyc;
         next_cyc();
         k = 0;
         while (!valid_a && k < 60) begin
            next_cyc();
            k++;
         end
         check("rr_id",  64'(id_a),  64'(exp_g[1]));
         check("rr_bcd", 64'(bcd_a), exp_g[1] ? 64'h222 : 64'h111);
         if (i == 3) req_a = 2'b00;
         next_cyc();
      end
      out_ready = 1'b0;
      next_cyc();

      // Asynchronous reset in the middle of a conversion
      start_conv(0, 2'b01, 32'd4294967295, "arst");
      repeat (14) @(posedge clk);
      #2;
      check("arst_busy_pre", 64'(busy_a), 64'd1);
      rst = 1'b1;
      #1;
      check("arst_valid", 64'(valid_a), 64'd0);
      check("arst_busy",  64'(busy_a),  64'd0);
      check("arst_ack",   64'(ack_a),   64'd0);
      check("arst_bcd",   64'(bcd_a),   64'd0);
      check("arst_id",    64'(id_a),    64'd0);
      check("arst_ovf",   64'(ovf_a),   64'd0);
      req_a = 2'b10; bin1_a = 32'd777;
      @(negedge clk);
      #1;
      check("arst_no_valid", 64'(valid_a), 64'd0);
      rst = 1'b0;
      start_conv(0, 2'b10, 32'd777, "arst_req1");
      wait_result(32, 40'h777, 1'b1, 1'b0, "arst_req1");
      handshake("arst_req1");

      // Seven-digit instance: overflow, then zero clears it
      start_conv(1, 2'b10, 32'd12345678, "ovf7");
      wait_result(32, 40'h2345678, 1'b1, 1'b1, "ovf7");
      handshake("ovf7");
      start_conv(1, 2'b10, 32'd0, "zero7");
      wait_result(32, 40'h0, 1'b1, 1'b0, "zero7");
      handshake("zero7");

      // Narrow 4-bit instance
      start_conv(2, 2'b01, 32'd15, "w4_15");
      wait_result(4, 40'h15, 1'b0, 1'b0, "w4_15");
      handshake("w4_15");
      start_conv(2, 2'b01, 32'd9, "w4_9");
      wait_result(4, 40'h09, 1'b0, 1'b0, "w4_9");
      handshake("w4_9");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
